msg_frame_reader: RTL and testbench

- Read-side master for the slave message store, sitting directly downstream of it.
- Per frame it issues a read-address sequence: addr 0 (header hi, also advances the slave message counter), addr 1 (header lo), then addr 2..PAYLOAD_LEN+1 (payload bytes from the slave RAM).
- Captures returned bytes after a fixed read latency and emits them as a valid/ready byte stream with last-flag and header/sequence status.
- Buffers returned bytes in a small FIFO so downstream backpressure never drops a read in flight.

---
 rtl/msg_frame_pkg.sv | 19 +
 rtl/msg_frame_fifo.sv | 50 +++++
 rtl/msg_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_msg_frame_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_frame_pkg.sv
// Shared types and address map for the message-frame read master.
// The kind tag travels with each read so the capture side knows what the returned byte is.
package msg_frame_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    typedef enum logic [1:0] {HDR_HI, HDR_LO, PAY, PAY_LAST} kind_e;

    localparam logic [15:0] HDR_ADDR_HI = 16'd0;
    localparam logic [15:0] HDR_ADDR_LO = 16'd1;
    localparam logic [15:0] PAY_BASE    = 16'd2;

    function automatic kind_e addr_kind(input logic [15:0] addr, input logic [15:0] last_addr);
        if (addr == HDR_ADDR_HI) return HDR_HI;
        if (addr == HDR_ADDR_LO) return HDR_LO;
        if (addr == last_addr)   return PAY_LAST;
        return PAY;
    endfunction

endpackage

// File: rtl/msg_frame_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module msg_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which words are meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/msg_frame_reader.sv
// Read master for the slave message store: issues header+payload reads, tracks them
// through a latency pipe, and streams payload bytes out through a capture FIFO.
module msg_frame_reader
    import msg_frame_pkg::*;
#(
    parameter int PAYLOAD_LEN = 16,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        new_msg,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] msg_id,
    output logic        seq_err,
    output logic        busy
);

    localparam logic [15:0] LAST_ADDR = PAY_BASE + 16'(PAYLOAD_LEN) - 16'd1;
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    logic          rd_req_q;
    logic [15:0]   rd_addr_q;
    kind_e         kind_q;
    logic [15:0]   next_addr_q;
    logic          new_msg_q;
    logic          busy_q;
    logic [RD_LAT-1:0] pipe_vld_q;
    kind_e         pipe_kind_q [RD_LAT];
    logic [7:0]    hdr_hi_q;
    logic [15:0]   msg_id_q;
    logic          seq_err_q;
    logic          seen_hdr_q;

    logic          tail_vld;
    kind_e         tail_kind;
    logic [15:0]   hdr_d;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [8:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [7:0]    occupancy;
    logic          can_issue;
    logic          drained;

    assign tail_vld  = pipe_vld_q[RD_LAT-1];
    assign tail_kind = pipe_kind_q[RD_LAT-1];
    assign hdr_d     = {hdr_hi_q, rd_data};
    assign fifo_push = tail_vld && (tail_kind == PAY || tail_kind == PAY_LAST);
    assign fifo_pop  = out_valid && out_ready;

    msg_frame_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({tail_kind == PAY_LAST, rd_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Every outstanding read owns a FIFO slot; a pop this cycle frees one early.
    always_comb begin
        // NOTE: assigned first on every path so no latch is inferred.
        occupancy = 8'(fifo_count);
        if (rd_req_q) occupancy = occupancy + 8'd1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pipe_vld_q[i]) occupancy = occupancy + 8'd1;
        end
        if (fifo_pop) occupancy = occupancy - 8'd1;
    end

    assign can_issue = occupancy < 8'(FIFO_DEPTH);
    assign drained   = !rd_req_q && (pipe_vld_q == '0) && fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            kind_q      <= HDR_HI;
            next_addr_q <= '0;
            new_msg_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so later lines still see pre-edge register values.
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            new_msg_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= ISSUE;
                    busy_q      <= 1'b1;
                    next_addr_q <= HDR_ADDR_HI;
                end
                ISSUE: if (can_issue) begin
                    rd_req_q    <= 1'b1;
                    rd_addr_q   <= next_addr_q;
                    kind_q      <= addr_kind(next_addr_q, LAST_ADDR);
                    next_addr_q <= next_addr_q + 16'd1;
                    if (next_addr_q == LAST_ADDR) state_q <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state_q   <= DONE;
                    new_msg_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The pipe follows the registered request, so its tail lines up with rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_kind_q[i] <= HDR_HI;
        end else begin
            pipe_vld_q[0]  <= rd_req_q;
            pipe_kind_q[0] <= kind_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_kind_q[i] <= pipe_kind_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_hi_q   <= '0;
            msg_id_q   <= '0;
            seq_err_q  <= 1'b0;
            seen_hdr_q <= 1'b0;
        end else if (tail_vld) begin
            case (tail_kind)
                HDR_HI: hdr_hi_q <= rd_data;
                HDR_LO: begin
                    if (seen_hdr_q && hdr_d != msg_id_q + 16'd1) seq_err_q <= 1'b1;
                    msg_id_q   <= hdr_d;
                    seen_hdr_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign new_msg   = new_msg_q;
    assign busy      = busy_q;
    assign msg_id    = msg_id_q;
    assign seq_err   = seq_err_q;
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head[7:0] : 8'h00;
    assign out_last  = out_valid && fifo_head[8];

endmodule

// File: tb/tb_msg_frame_reader.sv
// Scoreboard bench: a slave-store model answers reads, expected bytes are queued per frame
// and a negedge monitor compares every handshaken byte against them.
module tb_msg_frame_reader;

    localparam int PL    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, rd_req, new_msg, out_valid, out_ready, out_last, seq_err, busy;
    logic [15:0] rd_addr, msg_id;
    logic [7:0]  rd_data, out_data;

    int compared = 0;
    int mismatched = 0;

    msg_frame_reader #(.PAYLOAD_LEN(PL), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .new_msg(new_msg), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .msg_id(msg_id), .seq_err(seq_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave store model: address 0 returns header hi and advances its message counter.
    logic [15:0] cur_hdr = 16'h0;
    logic [7:0]  pay_mem [PL];
    logic [7:0]  sl_pipe [LAT];
    int          addr0_cnt = 0;
    int          cyc = 0;

    function automatic logic [7:0] slave_read(input logic [15:0] a);
        if (a == 16'd0) return cur_hdr[15:8];
        if (a == 16'd1) return cur_hdr[7:0];
        if (int'(a) - 2 < PL) return pay_mem[int'(a) - 2];
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sl_pipe[0] <= rd_req ? slave_read(rd_addr) : 8'($urandom);
        for (int i = 1; i < LAT; i++) sl_pipe[i] <= sl_pipe[i-1];
        if (rd_req && rd_addr == 16'd0) addr0_cnt <= addr0_cnt + 1;
    end
    assign rd_data = sl_pipe[LAT-1];

    // Reference model state
    logic [8:0]  exp_q [$];
    logic        exp_seen = 1'b0;
    logic [15:0] exp_msg_id = 16'h0;
    logic        exp_seq_err = 1'b0;

    int          newmsg_cnt = 0;
    int          pop_cnt = 0;
    logic [15:0] addr_log [$];
    int          cyc_log [$];
    int          rdy_mode = 0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic       held_vld;
        logic [8:0] held_val;
        logic [8:0] e;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_vld = 1'b0;
            end else begin
                if (rd_req) begin
                    addr_log.push_back(rd_addr);
                    cyc_log.push_back(cyc);
                end
                if (new_msg) newmsg_cnt++;
                if (dut.u_fifo.push_i)
                    check("fifo_slot_free", 32'(dut.u_fifo.count_o == DEPTH), 0);
                if (held_vld && out_valid) check("hold_stable", {out_last, out_data}, held_val);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[7:0]);
                        check("out_last", out_last, e[8]);
                        pop_cnt++;
                    end
                end
                held_vld = out_valid && !out_ready;
                held_val = {out_last, out_data};
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_new_msg", new_msg, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_msg_id", msg_id, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        exp_seen = 1'b0;
        exp_msg_id = 16'h0;
        exp_seq_err = 1'b0;
        @(negedge clk);
        check_reset_outputs();
    endtask

    task automatic start_frame(input logic [15:0] hdr, input bit fixed);
        cur_hdr = hdr;
        for (int i = 0; i < PL; i++) begin
            pay_mem[i] = fixed ? 8'(8'hA0 + i) : 8'($urandom);
            exp_q.push_back({(i == PL - 1), pay_mem[i]});
        end
        if (exp_seen && hdr != exp_msg_id + 16'd1) exp_seq_err = 1'b1;
        exp_msg_id = hdr;
        exp_seen = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int base = newmsg_cnt;
        for (int c = 0; c < 3000 && newmsg_cnt == base; c++) begin
            @(negedge clk); #1;
        end
        check("new_msg_pulses", newmsg_cnt - base, 1);
        check("stream_drained", exp_q.size(), 0);
        check("msg_id", msg_id, exp_msg_id);
        check("seq_err", seq_err, exp_seq_err);
        repeat (2) @(negedge clk);
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
        int nm_base, a0_base, p_base;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // Basic frame: fixed payload, consecutive ascending addresses
        addr_log.delete(); cyc_log.delete();
        start_frame(16'h0102, 1'b1);
        wait_done();
        check("basic_addr_count", addr_log.size(), PL + 2);
        for (int i = 0; i < addr_log.size(); i++) begin
            check("basic_addr", addr_log[i], i);
            check("basic_addr_cycle", cyc_log[i] - cyc_log[0], i);
        end

        // Sequence checking, sticky error, then 16-bit wrap after reset
        do_reset();
        start_frame(16'h0005, 1'b0); wait_done();
        start_frame(16'h0006, 1'b0); wait_done();
        start_frame(16'h0008, 1'b0); wait_done();
        start_frame(16'h0009, 1'b0); wait_done();
        do_reset();
        start_frame(16'hFFFF, 1'b0); wait_done();
        start_frame(16'h0000, 1'b0); wait_done();

        // Random backpressure over 8 frames
        rdy_mode = 1;
        nm_base = newmsg_cnt; a0_base = addr0_cnt;
        for (int f = 1; f <= 8; f++) begin
            start_frame(16'(f), 1'b0);
            wait_done();
        end
        check("rand_new_msg_total", newmsg_cnt - nm_base, 8);
        check("rand_addr0_total", addr0_cnt - a0_base, 8);

        // Full stall: issue stops once every slot is committed
        rdy_mode = 2;
        addr_log.delete(); cyc_log.delete();
        start_frame(16'h0009, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_issued", addr_log.size(), 6);
        check("stall_busy", busy, 1);
        check("stall_valid", out_valid, 1);
        rdy_mode = 0;
        wait_done();

        // start while busy is ignored
        nm_base = newmsg_cnt; a0_base = addr0_cnt;
        start_frame(16'h000A, 1'b0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_start_frames", newmsg_cnt - nm_base, 1);
        check("busy_start_addr0", addr0_cnt - a0_base, 1);

        // Reset after payload byte 3, then a non-sequential header must not flag
        p_base = pop_cnt;
        start_frame(16'h000B, 1'b0);
        for (int c = 0; c < 500 && pop_cnt - p_base < 3; c++) @(negedge clk);
        check("mid_bytes_before_rst", pop_cnt - p_base, 3);
        do_reset();
        nm_base = newmsg_cnt;
        repeat (30) @(negedge clk);
        check("mid_no_new_msg", newmsg_cnt - nm_base, 0);
        check("mid_idle", busy, 0);
        start_frame(16'h5555, 1'b0);
        wait_done();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
